// File: rtl/axi_sram_slave_if.sv
// AXI3 read/write channel bundle for axi_sram_slave (4-byte transfers, no size/lock/cache/prot).
interface axi_sram_slave_if #(
    parameter int unsigned ID_W = 4
);
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [3:0]      arlen;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [3:0]      awlen;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;

    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport slave (
        input  arid, araddr, arlen, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 responder over a word-addressed SRAM; independent read/write FSMs, one outstanding each.
// Optional random bubble insertion on R/W/B when AXI_SLV_RAND_STALL_EN is defined.
module axi_sram_slave #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned READ_LAT  = 2,
    parameter int unsigned ID_W      = 4
) (
    input  logic            aclk,
    input  logic            aresetn,
    axi_sram_slave_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned LAT_W = 4;
    localparam int unsigned LEN_W = 4;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BEAT} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    logic [31:0] mem [MEM_WORDS];

    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [LEN_W-1:0] len,
                                              input logic [1:0] burst);
        logic [31:0] inc;
        logic [31:0] mask;
        inc  = addr + 32'd4;
        // (len+1)*4-1 for the legal wrap lengths 1/3/7/15
        mask = {26'd0, len, 2'b11};
        if (burst == BURST_FIXED) return addr;
        if (burst == BURST_WRAP && (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15))
            return (addr & ~mask) | (inc & mask);
        return inc;
    endfunction

    function automatic logic out_of_range(input logic [31:0] addr);
        return addr[31:2] >= 30'(MEM_WORDS);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        return addr[IDX_W+1:2];
    endfunction

    logic stall_r, stall_w, stall_b;

`ifdef AXI_SLV_RAND_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) lfsr_q <= 16'hACE1;
        else          lfsr_q <= lfsr_d;
    end

    // wready is registered, so it is gated by the LFSR value of the cycle it is visible in
    assign stall_r = lfsr_q[0];
    assign stall_w = lfsr_d[1];
    assign stall_b = lfsr_q[2];
`else
    assign stall_r = 1'b0;
    assign stall_w = 1'b0;
    assign stall_b = 1'b0;
`endif

    // ---------------- read channel ----------------
    r_state_e          r_state_q, r_state_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic              rlast_q, rlast_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [31:0]       raddr_q, raddr_d;
    logic [LEN_W-1:0]  rlen_q, rlen_d;
    logic [1:0]        rburst_q, rburst_d;
    logic [LEN_W-1:0]  rcnt_q, rcnt_d;
    logic [LAT_W-1:0]  rlat_q, rlat_d;
    logic              r_launch;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rburst_q  <= '0;
            rcnt_q    <= '0;
            rlat_q    <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rid_q     <= rid_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rburst_q  <= rburst_d;
            rcnt_q    <= rcnt_d;
            rlat_q    <= rlat_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rid_d     = rid_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rburst_d  = rburst_q;
        rcnt_d    = rcnt_q;
        rlat_d    = rlat_q;
        r_launch  = 1'b0;

        case (r_state_q)
            R_IDLE: begin
                if (bus.arvalid && arready_q) begin
                    rid_d     = bus.arid;
                    raddr_d   = bus.araddr;
                    rlen_d    = bus.arlen;
                    rburst_d  = bus.arburst;
                    rcnt_d    = bus.arlen;
                    rlat_d    = LAT_W'(READ_LAT - 1);
                    arready_d = 1'b0;
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (rlat_q == '0) begin
                    r_state_d = R_BEAT;
                    r_launch  = !stall_r;
                end else begin
                    rlat_d = rlat_q - LAT_W'(1);
                end
            end
            R_BEAT: begin
                if (!rvalid_q) begin
                    r_launch = !stall_r;
                end else if (bus.rready) begin
                    rvalid_d = 1'b0;
                    if (rcnt_q == '0) begin
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        rcnt_d   = rcnt_q - LEN_W'(1);
                        raddr_d  = next_addr(raddr_q, rlen_q, rburst_q);
                        r_launch = !stall_r;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        // Beat data is sampled here, before any same-edge write lands
        if (r_launch) begin
            rvalid_d = 1'b1;
            rlast_d  = (rcnt_d == '0);
            if (out_of_range(raddr_d)) begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end else begin
                rdata_d = mem[word_idx(raddr_d)];
                rresp_d = RESP_OKAY;
            end
        end
    end

    // ---------------- write channel ----------------
    w_state_e          w_state_q, w_state_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [ID_W-1:0]   bid_q, bid_d;
    logic [ID_W-1:0]   wid_q, wid_d;
    logic [31:0]       waddr_q, waddr_d;
    logic [LEN_W-1:0]  wlen_q, wlen_d;
    logic [1:0]        wburst_q, wburst_d;
    logic [LEN_W-1:0]  wcnt_q, wcnt_d;
    logic              werr_q, werr_d;
    logic              mem_we;
    logic              w_oor;
    logic              unused_wlast;

    assign unused_wlast = bus.wlast;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= '0;
            wid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wburst_q  <= '0;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
            wid_q     <= wid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wburst_q  <= wburst_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        bid_d     = bid_q;
        wid_d     = wid_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wburst_d  = wburst_q;
        wcnt_d    = wcnt_q;
        werr_d    = werr_q;
        mem_we    = 1'b0;
        w_oor     = out_of_range(waddr_q);

        case (w_state_q)
            W_IDLE: begin
                if (bus.awvalid && awready_q) begin
                    wid_d     = bus.awid;
                    waddr_d   = bus.awaddr;
                    wlen_d    = bus.awlen;
                    wburst_d  = bus.awburst;
                    wcnt_d    = bus.awlen;
                    werr_d    = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = !stall_w;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                wready_d = !stall_w;
                if (bus.wvalid && wready_q) begin
                    mem_we = !w_oor;
                    // Beat count decides the end of the burst; wlast is not consulted
                    if (wcnt_q == '0) begin
                        wready_d  = 1'b0;
                        bresp_d   = (werr_q || w_oor) ? RESP_SLVERR : RESP_OKAY;
                        bid_d     = wid_q;
                        bvalid_d  = !stall_b;
                        w_state_d = W_RESP;
                    end else begin
                        werr_d  = werr_q | w_oor;
                        wcnt_d  = wcnt_q - LEN_W'(1);
                        waddr_d = next_addr(waddr_q, wlen_q, wburst_q);
                    end
                end
            end
            W_RESP: begin
                if (!bvalid_q) begin
                    bvalid_d = !stall_b;
                end else if (bus.bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Storage has no reset so contents survive aresetn
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b]) mem[word_idx(waddr_q)][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end

    assign bus.arready = arready_q;
    assign bus.rid     = rid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.rlast   = rlast_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bid     = bid_q;
    assign bus.bresp   = bresp_q;
    assign bus.bvalid  = bvalid_q;

endmodule
